uart_rx_fifo: RTL
=================

// Module: uart_rx_fifo
// PURPOSE
// - 8N1 UART receiver with buffered byte output; listens to the Nios UART transmit line (uart_0_txd) from the fabric side.
// - Lets fabric logic take commands from Nios software without polling; bytes leave through a valid/ready stream.
// - Detects framing errors and FIFO overruns and reports each as a single-cycle pulse.
// PARAMETERS
// - CLK_HZ      50_000_000  system clock frequency in Hz
// - BAUD        115200      line rate in bit/s
// - OVERSAMPLE  16          ticks per bit period; must be even and >= 8
// - FIFO_DEPTH  16          receive buffer entries; power of two, >= 2
// PORTS
// - clk_clk        in   1   single system clock
// - reset_reset_n  in   1   asynchronous, active-low reset
// - uart_rxd       in   1   serial input, idle high, asynchronous to clk_clk
// - rx_data        out  8   byte at FIFO head
// - rx_valid       out  1   FIFO not empty
// - rx_ready       in   1   consumer accepts; a pop occurs when rx_valid && rx_ready
// - rx_count       out  $clog2(FIFO_DEPTH)+1   current FIFO occupancy
// - frame_err      out  1   1-cycle pulse: stop bit sampled low
// - overrun        out  1   1-cycle pulse: received byte dropped because FIFO full
// BEHAVIOUR
// - Reset values: rx_data=0, rx_valid=0, rx_count=0, frame_err=0, overrun=0; FSM in IDLE; synchroniser flops=1.
// - Reset asserted mid-frame aborts the frame and empties the FIFO; no pulse is emitted.
// - Synchroniser: uart_rxd passes through 2 flops; all logic uses the synchronised bit rxs.
// - Tick: a free-running divider DIV=round(CLK_HZ/(BAUD*OVERSAMPLE)) pulses tick for 1 cycle every DIV clocks.
//   - DIV=0 is a compile-time error.
// - FSM states and transitions:
//   - IDLE:  on rxs falling edge (prev 1, now 0), clear the tick counter and go to START.
//   - START: after OVERSAMPLE/2 ticks, re-sample rxs.
//     - rxs=0: clear the counter and go to DATA.
//     - rxs=1: treat as a glitch and return to IDLE with no pulse.
//   - DATA:  every OVERSAMPLE ticks, shift rxs into the shift register, LSB first; after bit 7 go to STOP.
//   - STOP:  after OVERSAMPLE ticks, sample rxs.
//     - rxs=1: push the byte and go to IDLE.
//     - rxs=0: pulse frame_err, discard the byte, go to BREAK.
//   - BREAK: wait until rxs=1, then go to IDLE; this guarantees a break condition yields exactly one frame_err.
// - Push latency: the byte is visible on rx_data/rx_valid the cycle after the stop-bit sample (rx_data is FIFO head, registered).
// - FIFO boundary cases:
//   - Push while full with no same-cycle pop: drop the byte, pulse overrun; FIFO contents unchanged.
//   - Push while full with a same-cycle pop: accept the push, no overrun; count stays FIFO_DEPTH.
//   - Push and pop on an empty FIFO: the pop is not possible (rx_valid=0); the push completes and count becomes 1.
//   - Pointers wrap modulo FIFO_DEPTH; count is computed at full width, so a full FIFO reads FIFO_DEPTH, not 0.
// - The receiver accepts back-to-back frames: a start edge immediately after STOP→IDLE is honoured in the very next cycle.
// STRUCTURE
// - Package uart_pkg:
//   - enum rx_state_t {IDLE, START, DATA, STOP, BREAK};
//   - function calc_div(clk_hz, baud, os) and localparam DATA_BITS=8.
//   - uart_pkg is shared with a future uart_tx block.
// - Sub-module sync_fifo (WIDTH, DEPTH): registered head output, full/empty/count, same-cycle push+pop when full.
// - Top: synchroniser, tick divider, FSM/shift register, sync_fifo instance, pulse generation.
// TESTING (CLK_HZ=50e6, BAUD=115200 → DIV=27; bench drives uart_rxd at exact bit period 432 clk)
// - Send 0xA5, rx_ready=1 → one rx_valid beat with rx_data=0xA5; no frame_err, no overrun.
// - 0 pulse on uart_rxd of 100 clk (< half bit) → FSM returns to IDLE; no byte, no pulses.
// - Send 0x3C with stop bit 0, then hold the line low 20 bit times → exactly one frame_err pulse, no byte; next 0x11 received OK.
// - rx_ready=0, send 17 bytes 0x00..0x10 → count=16, one overrun pulse on byte 0x10; then drain → 0x00..0x0F in order.
// - Full FIFO with rx_ready=1 pulsed in the stop-sample cycle of a new byte 0x77 → no overrun, count stays 16, 0x77 last out.
// - Assert reset_reset_n=0 mid-DATA with 3 bytes buffered → rx_valid=0, count=0 immediately; next byte 0x5A received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame width and the baud divider helper.
package uart_pkg;

    localparam int unsigned DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } rx_state_t;

    // Rounded clocks-per-tick: round(clk_hz / (baud * os)).
    function automatic int unsigned calc_div(input int unsigned clk_hz,
                                             input int unsigned baud,
                                             input int unsigned os);
        int unsigned den;
        den = baud * os;
        return (clk_hz + den / 2) / den;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a registered head word, full-width occupancy count and
// push acceptance on a full FIFO when the same cycle also pops.
module sync_fifo #(
    parameter  int unsigned WIDTH = 8,
    parameter  int unsigned DEPTH = 16,
    localparam int unsigned CW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             valid,
    output logic [CW-1:0]    count,
    output logic             overrun_c
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    rd_ptr_d;
    logic [CW-1:0]    count_d;
    logic             empty;
    logic             full;
    logic             do_pop;
    logic             do_push;

    assign empty     = (count == '0);
    assign full      = (count == CW'(DEPTH));
    assign do_pop    = pop && !empty;
    assign do_push   = push && (!full || do_pop);
    assign overrun_c = push && !do_push;
    assign rd_ptr_d  = do_pop ? rd_ptr + AW'(1) : rd_ptr;
    assign count_d   = count + CW'(do_push) - CW'(do_pop);

    // Head register: bypass the incoming word when it lands in the slot that becomes the head.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            valid   <= 1'b0;
            rd_data <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            rd_ptr <= rd_ptr_d;
            count  <= count_d;
            valid  <= (count_d != '0);
            if (do_push && (wr_ptr == rd_ptr_d)) begin
                rd_data <= wr_data;
            end else if (count_d != '0) begin
                rd_data <= mem[rd_ptr_d];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver feeding a byte FIFO drained through a valid/ready stream;
// framing errors and dropped bytes are reported as single-cycle pulses.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter  int unsigned CLK_HZ     = 50_000_000,
    parameter  int unsigned BAUD       = 115_200,
    parameter  int unsigned OVERSAMPLE = 16,
    parameter  int unsigned FIFO_DEPTH = 16,
    localparam int unsigned CW         = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                 clk_clk,
    input  logic                 reset_reset_n,
    input  logic                 uart_rxd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic [CW-1:0]        rx_count,
    output logic                 frame_err,
    output logic                 overrun
);

    localparam int unsigned DIV = calc_div(CLK_HZ, BAUD, OVERSAMPLE);
    localparam int unsigned DW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned OW  = $clog2(OVERSAMPLE);
    localparam int unsigned BW  = $clog2(DATA_BITS);

    if (DIV == 0) begin : g_bad_div
        $error("uart_rx_fifo: baud divider rounds to zero");
    end

    logic                 rxd_meta;
    logic                 rxs;
    logic                 rxs_q;
    logic [DW-1:0]        div_cnt;
    logic                 tick;
    rx_state_t            state, state_d;
    logic [OW-1:0]        os_cnt, os_cnt_d;
    logic [BW-1:0]        bit_cnt, bit_cnt_d;
    logic [DATA_BITS-1:0] shreg, shreg_d;
    logic                 frame_err_d;
    logic                 push_c;
    logic                 overrun_c;

    // Two-flop synchroniser plus one delayed copy for start-edge detection.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            rxd_meta <= 1'b1;
            rxs      <= 1'b1;
            rxs_q    <= 1'b1;
        end else begin
            rxd_meta <= uart_rxd;
            rxs      <= rxd_meta;
            rxs_q    <= rxs;
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            div_cnt <= '0;
            tick    <= 1'b0;
        end else if (div_cnt == DW'(DIV - 1)) begin
            div_cnt <= '0;
            tick    <= 1'b1;
        end else begin
            div_cnt <= div_cnt + DW'(1);
            tick    <= 1'b0;
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state     <= IDLE;
            os_cnt    <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            state     <= state_d;
            os_cnt    <= os_cnt_d;
            bit_cnt   <= bit_cnt_d;
            shreg     <= shreg_d;
            frame_err <= frame_err_d;
            overrun   <= overrun_c;
        end
    end

    always_comb begin
        state_d     = state;
        os_cnt_d    = os_cnt;
        bit_cnt_d   = bit_cnt;
        shreg_d     = shreg;
        frame_err_d = 1'b0;
        push_c      = 1'b0;
        unique case (state)
            IDLE: begin
                if (rxs_q && !rxs) begin
                    os_cnt_d = '0;
                    state_d  = START;
                end
            end
            // Mid-start-bit check rejects glitches shorter than half a bit.
            START: begin
                if (tick) begin
                    if (os_cnt == OW'(OVERSAMPLE / 2 - 1)) begin
                        os_cnt_d  = '0;
                        bit_cnt_d = '0;
                        state_d   = rxs ? IDLE : DATA;
                    end else begin
                        os_cnt_d = os_cnt + OW'(1);
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (os_cnt == OW'(OVERSAMPLE - 1)) begin
                        os_cnt_d  = '0;
                        shreg_d   = {rxs, shreg[DATA_BITS-1:1]};
                        bit_cnt_d = bit_cnt + BW'(1);
                        if (bit_cnt == BW'(DATA_BITS - 1)) begin
                            state_d = STOP;
                        end
                    end else begin
                        os_cnt_d = os_cnt + OW'(1);
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (os_cnt == OW'(OVERSAMPLE - 1)) begin
                        os_cnt_d = '0;
                        if (rxs) begin
                            push_c  = 1'b1;
                            state_d = IDLE;
                        end else begin
                            frame_err_d = 1'b1;
                            state_d     = BREAK;
                        end
                    end else begin
                        os_cnt_d = os_cnt + OW'(1);
                    end
                end
            end
            // A held-low line reports one framing error, then waits for idle.
            BREAK: begin
                if (rxs) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk_clk),
        .rst_n     (reset_reset_n),
        .push      (push_c),
        .wr_data   (shreg),
        .pop       (rx_ready),
        .rd_data   (rx_data),
        .valid     (rx_valid),
        .count     (rx_count),
        .overrun_c (overrun_c)
    );

endmodule
